// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared state encoding and default constants for the 68k bus arbiter.
// Optional grant timeout is enabled by defining M68K_ARB_TIMEOUT_EN.
package m68k_arb_pkg;

    typedef enum logic [1:0] {
        ST_OWN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GRANT = 2'd2,
        ST_EXT   = 2'd3
    } arb_state_e;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int TIMEOUT_CYCLES_DEF = 256;
    localparam int CNT_W              = 16;

endpackage

// File: rtl/m68k_bus_arbiter_if.sv
// Bus-side and sequencer-side signals of the 68k bus arbiter.
// slave = arbiter view, master = environment view.
interface m68k_bus_arbiter_if;

    logic M68K_BR_n;
    logic M68K_BGACK_n;
    logic M68K_BG_n;
    logic txn_req;
    logic txn_busy;
    logic txn_gnt;
    logic ext_owner;
    logic timeout_clr;
    logic arb_timeout;

    modport slave (
        input  M68K_BR_n,
        input  M68K_BGACK_n,
        input  txn_req,
        input  txn_busy,
        input  timeout_clr,
        output M68K_BG_n,
        output txn_gnt,
        output ext_owner,
        output arb_timeout
    );

    modport master (
        output M68K_BR_n,
        output M68K_BGACK_n,
        output txn_req,
        output txn_busy,
        output timeout_clr,
        input  M68K_BG_n,
        input  txn_gnt,
        input  ext_owner,
        input  arb_timeout
    );

endinterface

// File: rtl/m68k_bus_arbiter_pi_sync.sv
// Multi-flop synchronizer for asynchronous active-low bus inputs.
// Resets to 1 so a held-in-reset bus reads as deasserted.
module pi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Arbitrates the 68k bus between the local sequencer and an external master.
// Define M68K_ARB_TIMEOUT_EN to withdraw an unacknowledged grant.
module m68k_bus_arbiter
    import m68k_arb_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic               PI_CLK,
    input logic               RESET_n,
    m68k_bus_arbiter_if.slave bus
);

    logic br_sync;
    logic bgack_sync;
    logic br_s;
    logic bgack_s;

    pi_sync #(.STAGES(SYNC_STAGES)) u_sync_br (
        .clk_i   (PI_CLK),
        .rst_n_i (RESET_n),
        .d_i     (bus.M68K_BR_n),
        .q_o     (br_sync)
    );

    pi_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .clk_i   (PI_CLK),
        .rst_n_i (RESET_n),
        .d_i     (bus.M68K_BGACK_n),
        .q_o     (bgack_sync)
    );

    assign br_s    = ~br_sync;
    assign bgack_s = ~bgack_sync;

    arb_state_e state_q;
    arb_state_e state_d;
    logic       bg_n_q;
    logic       bg_n_d;
    logic       run_q;
    logic       tmo_evt;
    logic       unused_w;

`ifdef M68K_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tmo_q;
    logic             tmo_d;

    assign tmo_evt = (state_q == ST_GRANT) && !bgack_s
                     && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_GRANT && state_d == ST_GRANT) begin
            cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q == ST_GRANT && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // A timeout in the same cycle as a clear keeps the flag set
    always_comb begin
        tmo_d = tmo_q;
        if (tmo_evt) begin
            tmo_d = 1'b1;
        end else if (bus.timeout_clr) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.arb_timeout = tmo_q;
    assign unused_w        = bus.txn_req;
`else
    assign tmo_evt         = 1'b0;
    assign bus.arb_timeout = 1'b0;
    assign unused_w        = bus.txn_req ^ bus.timeout_clr
                             ^ TIMEOUT_CYCLES[0];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OWN: begin
                if (br_s) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.txn_busy) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (bgack_s) begin
                    state_d = ST_EXT;
                end else if (tmo_evt || !br_s) begin
                    state_d = ST_OWN;
                end
            end
            ST_EXT: begin
                if (!bgack_s) state_d = ST_OWN;
            end
            default: state_d = ST_OWN;
        endcase
    end

    assign bg_n_d = (state_d != ST_GRANT);

    // run_q keeps txn_gnt low until the first edge after reset
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_OWN;
            bg_n_q  <= 1'b1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bg_n_q  <= bg_n_d;
            run_q   <= 1'b1;
        end
    end

    assign bus.M68K_BG_n = bg_n_q;
    assign bus.ext_owner = (state_q == ST_EXT);
    assign bus.txn_gnt   = run_q && (state_q == ST_OWN) && !br_s;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter: vector table plus reset/timeout
// sequences (timeout part active when M68K_ARB_TIMEOUT_EN is defined).
module tb_m68k_bus_arbiter;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    m68k_bus_arbiter_if bus ();

    m68k_bus_arbiter #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PI_CLK  (clk),
        .RESET_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic br_n;
        logic bgack_n;
        logic req;
        logic busy;
        int   n;
        logic gnt;
        logic bg_n;
        logic ext;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic br_n, logic bgack_n, logic req,
                                logic busy, int n, logic gnt,
                                logic bg_n, logic ext);
        vec_t v;
        v.br_n    = br_n;
        v.bgack_n = bgack_n;
        v.req     = req;
        v.busy    = busy;
        v.n       = n;
        v.gnt     = gnt;
        v.bg_n    = bg_n;
        v.ext     = ext;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        if (n == 0) begin
            #1;
        end else begin
            repeat (n) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_outs(input string nm, input logic gnt,
                            input logic bg_n, input logic ext);
        chk({nm, "_gnt"}, 16'(bus.txn_gnt), 16'(gnt));
        chk({nm, "_bg"}, 16'(bus.M68K_BG_n), 16'(bg_n));
        chk({nm, "_ext"}, 16'(bus.ext_owner), 16'(ext));
        chk({nm, "_tmo"}, 16'(bus.arb_timeout), 16'd0);
    endtask

    initial begin
        int n;

        rst_n            = 1'b0;
        bus.M68K_BR_n    = 1'b1;
        bus.M68K_BGACK_n = 1'b1;
        bus.txn_req      = 1'b0;
        bus.txn_busy     = 1'b0;
        bus.timeout_clr  = 1'b0;

        // br_n bgack_n req busy n | gnt bg_n ext
        vecs.push_back(mk(1, 1, 1, 0,  1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1,  1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1,  1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 17, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  9, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,  5, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  2, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,  2, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0,  1, 1, 1, 0));

        @(negedge clk);
        @(negedge clk);
        chk_outs("reset", 1'b0, 1'b1, 1'b0);

        rst_n = 1'b1;
        #1;
        chk("rel_gnt_early", 16'(bus.txn_gnt), 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_gnt_edge", 16'(bus.txn_gnt), 16'd1);

        foreach (vecs[i]) begin
            bus.M68K_BR_n    = vecs[i].br_n;
            bus.M68K_BGACK_n = vecs[i].bgack_n;
            bus.txn_req      = vecs[i].req;
            bus.txn_busy     = vecs[i].busy;
            wait_cyc(vecs[i].n);
            chk_outs($sformatf("v%0d", i), vecs[i].gnt,
                     vecs[i].bg_n, vecs[i].ext);
        end

        // Reset while the external master owns the bus
        bus.txn_req  = 1'b0;
        bus.txn_busy = 1'b0;
        bus.M68K_BR_n = 1'b0;
        wait_cyc(4);
        chk("rx_grant_bg", 16'(bus.M68K_BG_n), 16'd0);
        bus.M68K_BGACK_n = 1'b0;
        wait_cyc(3);
        chk("rx_ext", 16'(bus.ext_owner), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_ext", 1'b0, 1'b1, 1'b0);
        bus.M68K_BR_n    = 1'b1;
        bus.M68K_BGACK_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("rx_recover_gnt", 16'(bus.txn_gnt), 16'd1);

        // Reset while BG is asserted
        bus.M68K_BR_n = 1'b0;
        wait_cyc(4);
        chk("rg_grant_bg", 16'(bus.M68K_BG_n), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_grant", 1'b0, 1'b1, 1'b0);
        bus.M68K_BR_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("rg_recover_gnt", 16'(bus.txn_gnt), 16'd1);

`ifdef M68K_ARB_TIMEOUT_EN
        bus.M68K_BR_n = 1'b0;
        n = 0;
        while (bus.M68K_BG_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_grant", 16'(bus.M68K_BG_n), 16'd0);
        n = 0;
        while (!bus.M68K_BG_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_len", 16'(n), 16'(TMO));
        chk("tmo_flag", 16'(bus.arb_timeout), 16'd1);
        chk("tmo_bg_rel", 16'(bus.M68K_BG_n), 16'd1);
        bus.timeout_clr = 1'b1;
        wait_cyc(1);
        chk("tmo_clr", 16'(bus.arb_timeout), 16'd0);
        n = 0;
        while (bus.M68K_BG_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_regrant", 16'(bus.M68K_BG_n), 16'd0);
        n = 0;
        while (!bus.M68K_BG_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_len2", 16'(n), 16'(TMO));
        chk("tmo_set_wins", 16'(bus.arb_timeout), 16'd1);
        wait_cyc(1);
        chk("tmo_clr2", 16'(bus.arb_timeout), 16'd0);
        bus.timeout_clr = 1'b0;
        bus.M68K_BR_n   = 1'b1;
        wait_cyc(5);
        chk("tmo_idle_gnt", 16'(bus.txn_gnt), 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
